// File: rtl/bus_burst_slave.sv
// bus_burst_slave
//   Burst-capable memory slave on the shared processor bus. Decodes a single
//   address window at BASE_ADDR and backs it with a 2^ADDR_BITS x 32 word
//   memory. Serves single/burst reads (fixed WAIT_CYCLES latency, master
//   stall via in_busy) and writes (byte enables, optional periodic out_busy),
//   and flags bursts running past the end of the window with out_error.
//
// Ports
//   clock, reset           clock; asynchronous active-high reset
//   in_beginTransaction    start of transaction, address/control valid
//   in_endTransaction      end of write burst, or abort of a read
//   in_addressData  [31:0] address on begin cycle, write data otherwise
//   in_readNotWrite        1 = read, 0 = write (begin cycle)
//   in_burstSize    [7:0]  words-1 (begin cycle)
//   in_byteEnable   [3:0]  write byte lanes (begin cycle)
//   in_dataValid           write word valid
//   in_busy                master stalls read data
//   out_addressData [31:0] read data, 0 when out_dataValid=0
//   out_dataValid          read word valid
//   out_endTransaction     one-cycle pulse closing a read burst
//   out_busy               slave stalls write data
//   out_error              one-cycle pulse for an out-of-window burst
//   All outputs are registered and idle at 0 (wired-OR bus).

module bus_burst_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'h50000000,
  parameter int          ADDR_BITS   = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter int          BUSY_PERIOD = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_beginTransaction,
  input  logic        in_endTransaction,
  input  logic [31:0] in_addressData,
  input  logic        in_readNotWrite,
  input  logic [7:0]  in_burstSize,
  input  logic [3:0]  in_byteEnable,
  input  logic        in_dataValid,
  input  logic        in_busy,
  output logic [31:0] out_addressData,
  output logic        out_dataValid,
  output logic        out_endTransaction,
  output logic        out_busy,
  output logic        out_error
);

  localparam int WORDS = 1 << ADDR_BITS;
  localparam int BP    = (BUSY_PERIOD > 0) ? BUSY_PERIOD : 1;

  typedef enum logic [2:0] {
    IDLE, READ_WAIT, READ_BURST, READ_END, WRITE_BURST, ERROR
  } state_t;

  // Transfer direction is resolved by the state chosen on the begin cycle,
  // so only the addressing and lane controls need to be held.
  typedef struct packed {
    logic [ADDR_BITS-1:0] wordAddr;
    logic [7:0]           burstSize;
    logic [3:0]           byteEnable;
  } req_t;

  state_t               state, stateNext;
  req_t                 req;
  logic [8:0]           count;     // words transferred in this burst
  logic [3:0]           waitCnt;
  logic [15:0]          busyCnt;   // accepted words since last busy pulse
  logic [31:0]          mem [WORDS];

  logic                 decSel, decOvf;
  logic [ADDR_BITS-1:0] decWord;
  logic [31:0]          decEnd;
  logic                 waitDone, xfer, lastXfer, wrAcc, busyHit;
  logic [ADDR_BITS-1:0] rdAddr, wrAddr;
  logic [31:0]          rdWord;

  logic [31:0]          dataD;
  logic                 dvD, endD, busyD, errD;

  // ---------------------------------------------------------------- decode
  assign decSel  = in_beginTransaction &
                   (in_addressData[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign decWord = in_addressData[ADDR_BITS+1:2];
  // Wide sum so a burst past the top of the window is caught, not wrapped.
  assign decEnd  = 32'(decWord) + 32'(in_burstSize);
  assign decOvf  = decEnd > 32'(WORDS - 1);

  assign waitDone = (waitCnt == 4'(WAIT_CYCLES - 1));
  assign xfer     = out_dataValid & ~in_busy;
  assign lastXfer = xfer & (count == {1'b0, req.burstSize});
  assign wrAcc    = (state == WRITE_BURST) & in_dataValid & ~out_busy &
                    (count <= {1'b0, req.burstSize});
  assign busyHit  = (BUSY_PERIOD > 0) && (busyCnt == 16'(BP - 1));

  // Read port: the word placed on the bus next. From IDLE (zero wait) the
  // request is not latched yet, so the decoded address is used directly.
  always_comb begin
    rdAddr = req.wordAddr + ADDR_BITS'(count) + ADDR_BITS'(1);
    if (state == IDLE)           rdAddr = decWord;
    else if (state == READ_WAIT) rdAddr = req.wordAddr;
  end
  assign rdWord = mem[rdAddr];
  assign wrAddr = req.wordAddr + ADDR_BITS'(count);

  // ----------------------------------------------------------- state reg
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= stateNext;
  end

  // ---------------------------------------------------------- next state
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:
        if (decSel) begin
          if (decOvf)               stateNext = ERROR;
          else if (!in_readNotWrite) stateNext = WRITE_BURST;
          else if (WAIT_CYCLES > 0)  stateNext = READ_WAIT;
          else                       stateNext = READ_BURST;
        end
      READ_WAIT:
        if (in_endTransaction) stateNext = IDLE;
        else if (waitDone)     stateNext = READ_BURST;
      READ_BURST:
        if (in_endTransaction) stateNext = IDLE;
        else if (lastXfer)     stateNext = READ_END;
      WRITE_BURST:
        if (in_endTransaction) stateNext = IDLE;
      READ_END: stateNext = IDLE;
      ERROR:    stateNext = IDLE;
      default:  stateNext = IDLE;
    endcase
  end

  // ------------------------------------------------ output next values
  always_comb begin
    dvD   = 1'b0;
    dataD = '0;
    endD  = 1'b0;
    busyD = 1'b0;
    errD  = 1'b0;
    case (state)
      IDLE:
        if (decSel) begin
          if (decOvf) errD = 1'b1;
          else if (in_readNotWrite && WAIT_CYCLES == 0) begin
            dvD   = 1'b1;
            dataD = rdWord;
          end
        end
      READ_WAIT:
        if (!in_endTransaction && waitDone) begin
          dvD   = 1'b1;
          dataD = rdWord;
        end
      READ_BURST:
        if (!in_endTransaction) begin
          if (!xfer) begin
            // master stalled: hold the presented word
            dvD   = out_dataValid;
            dataD = out_addressData;
          end else if (lastXfer) begin
            endD = 1'b1;
          end else begin
            dvD   = 1'b1;
            dataD = rdWord;
          end
        end
      WRITE_BURST:
        busyD = !in_endTransaction && wrAcc && busyHit;
      default: ;
    endcase
  end

  // -------------------------------------------- counters and output regs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      req                <= '0;
      count              <= '0;
      waitCnt            <= '0;
      busyCnt            <= '0;
      out_addressData    <= '0;
      out_dataValid      <= 1'b0;
      out_endTransaction <= 1'b0;
      out_busy           <= 1'b0;
      out_error          <= 1'b0;
    end else begin
      out_addressData    <= dataD;
      out_dataValid      <= dvD;
      out_endTransaction <= endD;
      out_busy           <= busyD;
      out_error          <= errD;
      case (state)
        IDLE:
          if (decSel) begin
            req.wordAddr   <= decWord;
            req.burstSize  <= in_burstSize;
            req.byteEnable <= in_byteEnable;
            count          <= '0;
            waitCnt        <= '0;
            busyCnt        <= '0;
          end
        READ_WAIT:  waitCnt <= waitCnt + 4'd1;
        READ_BURST: if (xfer) count <= count + 9'd1;
        WRITE_BURST:
          if (wrAcc) begin
            count   <= count + 9'd1;
            busyCnt <= busyHit ? 16'd0 : busyCnt + 16'd1;
          end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- memory
  // Contents survive reset; writes merge byte lanes into the addressed word.
  always_ff @(posedge clock) begin
    if (wrAcc) begin
      for (int b = 0; b < 4; b++)
        if (req.byteEnable[b]) mem[wrAddr][8*b +: 8] <= in_addressData[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_bus_burst_slave.sv
// Scoreboard bench for bus_burst_slave (WAIT_CYCLES=2, BUSY_PERIOD=2).
// Stimulus tasks push the expected read words, end pulses, error pulses and
// busy pulses into a queue; a negedge monitor pops and compares whenever the
// slave drives an output.

module tb_bus_burst_slave;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_beginTransaction, in_endTransaction, in_readNotWrite;
  logic [31:0] in_addressData;
  logic [7:0]  in_burstSize;
  logic [3:0]  in_byteEnable;
  logic        in_dataValid, in_busy;
  logic [31:0] out_addressData;
  logic        out_dataValid, out_endTransaction, out_busy, out_error;

  localparam int BP = 2;

  bus_burst_slave #(
    .BASE_ADDR(32'h50000000), .ADDR_BITS(10), .WAIT_CYCLES(2), .BUSY_PERIOD(BP)
  ) dut (
    .clock(clock), .reset(reset),
    .in_beginTransaction(in_beginTransaction), .in_endTransaction(in_endTransaction),
    .in_addressData(in_addressData), .in_readNotWrite(in_readNotWrite),
    .in_burstSize(in_burstSize), .in_byteEnable(in_byteEnable),
    .in_dataValid(in_dataValid), .in_busy(in_busy),
    .out_addressData(out_addressData), .out_dataValid(out_dataValid),
    .out_endTransaction(out_endTransaction), .out_busy(out_busy),
    .out_error(out_error)
  );

  always #5 clock = ~clock;

  typedef enum int {K_DATA, K_END, K_ERR, K_BUSY} kind_e;
  typedef struct {
    kind_e       kind;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  int          nAssert = 0;
  int          nFail   = 0;
  bit          monOn   = 1'b1;
  bit          holdPending = 1'b0;
  logic [31:0] holdData = '0;
  logic [31:0] vec [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nAssert++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic popChk(input string name, input kind_e k, input logic [31:0] d);
    exp_t e;
    nAssert++;
    if (q.size() == 0) begin
      nFail++;
      $display("FAIL %s: unexpected output kind %0d data %h at %0t", name, k, d, $time);
    end else begin
      e = q.pop_front();
      if (e.kind != k || e.data !== d) begin
        nFail++;
        $display("FAIL %s: got kind %0d data %h, expected kind %0d data %h at %0t",
                 name, k, d, e.kind, e.data, $time);
      end
    end
  endtask

  // Monitor: compares each bus event against the head of the scoreboard.
  always @(negedge clock) begin
    if (reset || !monOn) begin
      holdPending = 1'b0;
    end else begin
      if (holdPending) begin
        chk("rdHoldValid", 32'(out_dataValid), 32'd1);
        chk("rdHoldData", out_addressData, holdData);
      end
      if (out_dataValid && !in_busy) popChk("rdWord", K_DATA, out_addressData);
      if (!out_dataValid) chk("rdIdleZero", out_addressData, 32'd0);
      if (out_endTransaction) popChk("rdEnd", K_END, 32'd0);
      if (out_error) popChk("errPulse", K_ERR, 32'd0);
      if (out_busy) popChk("busyPulse", K_BUSY, 32'd0);
      holdPending = out_dataValid && in_busy;
      holdData    = out_addressData;
    end
  end

  task automatic idleInputs();
    in_beginTransaction = 0; in_endTransaction = 0; in_addressData = 0;
    in_readNotWrite = 0; in_burstSize = 0; in_byteEnable = 0;
    in_dataValid = 0; in_busy = 0;
  endtask

  // Write vec[0..n-1]; busy is expected the cycle after every BP-th word.
  task automatic writeBurst(input logic [31:0] addr, input logic [3:0] be, input int n);
    int i = 0;
    for (int k = 1; k <= n; k++) if (k % BP == 0) q.push_back('{K_BUSY, 32'd0});
    in_beginTransaction = 1; in_addressData = addr; in_readNotWrite = 0;
    in_burstSize = 8'(n - 1); in_byteEnable = be;
    @(posedge clock); #1;
    in_beginTransaction = 0;
    for (int g = 0; g < 100 && i < n; g++) begin
      in_dataValid = 1; in_addressData = vec[i];
      @(negedge clock);
      if (!out_busy) i++;
      @(posedge clock); #1;
    end
    in_dataValid = 0; in_addressData = 0; in_endTransaction = 1;
    @(posedge clock); #1;
    in_endTransaction = 0;
    chk("wrWordsAccepted", 32'(i), 32'(n));
  endtask

  // Read n words expecting vec[]; stall with in_busy on data cycles
  // [stStart, stStart+stLen).
  task automatic readBurst(input logic [31:0] addr, input int n, input int stStart, input int stLen);
    int lat = 0;
    int dvCyc = 0;
    bit sawEnd = 0;
    for (int i = 0; i < n; i++) q.push_back('{K_DATA, vec[i]});
    q.push_back('{K_END, 32'd0});
    in_beginTransaction = 1; in_addressData = addr; in_readNotWrite = 1;
    in_burstSize = 8'(n - 1); in_byteEnable = 0;
    @(posedge clock); #1;
    in_beginTransaction = 0; in_addressData = 0; in_readNotWrite = 0;
    for (int c = 1; c <= 60 && !sawEnd; c++) begin
      @(negedge clock);
      if (out_dataValid) begin
        if (lat == 0) lat = c;
        dvCyc++;
      end
      if (out_endTransaction) sawEnd = 1;
      @(posedge clock); #1;
      in_busy = (lat > 0) && (stLen > 0) && (c + 1 - lat >= stStart) &&
                (c + 1 - lat < stStart + stLen);
    end
    in_busy = 0;
    chk("rdLatency", 32'(lat), 32'd3);
    chk("rdValidCycles", 32'(dvCyc), 32'(n + stLen));
    chk("rdEndSeen", 32'(sawEnd), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int act;
    idleInputs();
    reset = 1;
    repeat (2) @(posedge clock);
    #1;
    chk("rstOutputs", {out_addressData[30:0], out_dataValid} | 32'(out_addressData[31]) |
        32'({out_endTransaction, out_busy, out_error}), 32'd0);
    reset = 0;
    @(posedge clock); #1;

    // write then read, then same read with a 2-cycle stall on word 1
    vec = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    writeBurst(32'h50000010, 4'hF, 4);
    readBurst(32'h50000010, 4, 0, 0);
    readBurst(32'h50000010, 4, 1, 2);

    // byte enables
    vec[0] = 32'hAABBCCDD;
    writeBurst(32'h50000000, 4'hF, 1);
    vec[0] = 32'h11223344;
    writeBurst(32'h50000000, 4'b0101, 1);
    vec[0] = 32'hAA22CC44;
    readBurst(32'h50000000, 1, 0, 0);

    // burst ending exactly at the last word is legal
    vec = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
    writeBurst(32'h50000FF0, 4'hF, 4);

    // illegal write burst: error pulse, data ignored
    q.push_back('{K_ERR, 32'd0});
    in_beginTransaction = 1; in_addressData = 32'h50000FF0; in_readNotWrite = 0;
    in_burstSize = 8'd7; in_byteEnable = 4'hF;
    @(posedge clock); #1;
    in_beginTransaction = 0;
    for (int i = 0; i < 4; i++) begin
      in_dataValid = 1; in_addressData = 32'hDEAD0000 + 32'(i);
      @(posedge clock); #1;
    end
    in_dataValid = 0; in_addressData = 0; in_endTransaction = 1;
    @(posedge clock); #1;
    in_endTransaction = 0;

    // illegal read burst
    q.push_back('{K_ERR, 32'd0});
    in_beginTransaction = 1; in_addressData = 32'h50000FF0; in_readNotWrite = 1;
    in_burstSize = 8'd7;
    @(posedge clock); #1;
    idleInputs();
    repeat (4) @(posedge clock);
    #1;
    readBurst(32'h50000FF0, 4, 0, 0);

    // decode miss: no activity for 20 cycles
    act = 0;
    in_beginTransaction = 1; in_addressData = 32'h40000000; in_readNotWrite = 1;
    in_burstSize = 8'd3;
    @(posedge clock); #1;
    idleInputs();
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (out_dataValid || out_endTransaction || out_busy || out_error || out_addressData != 0) act++;
    end
    chk("missActivity", 32'(act), 32'd0);
    @(posedge clock); #1;

    // periodic busy over a 6-word write
    vec = '{32'h101, 32'h202, 32'h303, 32'h404, 32'h505, 32'h606, 0, 0};
    writeBurst(32'h50000100, 4'hF, 6);
    readBurst(32'h50000100, 6, 0, 0);

    // reset in the middle of a read
    monOn = 0;
    in_beginTransaction = 1; in_addressData = 32'h50000010; in_readNotWrite = 1;
    in_burstSize = 8'd3;
    @(posedge clock); #1;
    idleInputs();
    act = 0;
    for (int c = 0; c < 20 && act == 0; c++) begin
      @(negedge clock);
      if (out_dataValid) act = 1;
    end
    chk("midReadStarted", 32'(act), 32'd1);
    @(posedge clock); @(posedge clock); #1;
    reset = 1;
    #1;
    chk("rstMidData", out_addressData, 32'd0);
    chk("rstMidCtl", 32'({out_dataValid, out_endTransaction, out_busy, out_error}), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    act = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      if (out_dataValid || out_endTransaction || out_busy || out_error) act++;
    end
    chk("postRstIdle", 32'(act), 32'd0);
    @(posedge clock); #1;
    monOn = 1;
    vec = '{32'h11, 32'h22, 32'h33, 32'h44, 0, 0, 0, 0};
    readBurst(32'h50000010, 4, 0, 0);

    repeat (4) @(posedge clock);
    #1;
    chk("scoreboardEmpty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
